ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/mips_pkg.sv | 102 ++++++++++
 rtl/ex_multiplier.sv | 86 ++++++++
 rtl/ex_stage.sv | 138 +++++++++++++
 tb/tb_ex_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings, payload structs and decode helper for the MIPS execute stage.
package mips_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned PROD_W    = 2 * XLEN;
  localparam int unsigned REG_AW    = 5;
  localparam int unsigned CTRL_W    = 7;
  localparam int unsigned EX_CTRL_W = 5;
  localparam int unsigned LMODE_W   = 2;
  localparam int unsigned ALUOP_W   = 3;
  localparam int unsigned FUNCT_W   = 6;
  localparam int unsigned MUL_CNT_W = 5;

  // Bit positions inside id_ctrl = {RegDst,RegWrite,ALUSrc,MemWrite,MemRead,MemToReg,Branch}
  localparam int unsigned CTRL_REG_DST   = 6;
  localparam int unsigned CTRL_REG_WRITE = 5;
  localparam int unsigned CTRL_ALU_SRC   = 4;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b000;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b001;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 3'b010;
  localparam logic [ALUOP_W-1:0] ALUOP_AND   = 3'b011;
  localparam logic [ALUOP_W-1:0] ALUOP_OR    = 3'b100;
  localparam logic [ALUOP_W-1:0] ALUOP_SLT   = 3'b101;
  localparam logic [ALUOP_W-1:0] ALUOP_LUI   = 3'b110;
  localparam logic [ALUOP_W-1:0] ALUOP_XOR   = 3'b111;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD  = 6'h20;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB  = 6'h22;
  localparam logic [FUNCT_W-1:0] FUNCT_AND  = 6'h24;
  localparam logic [FUNCT_W-1:0] FUNCT_OR   = 6'h25;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT  = 6'h2A;
  localparam logic [FUNCT_W-1:0] FUNCT_SLL  = 6'h00;
  localparam logic [FUNCT_W-1:0] FUNCT_SRL  = 6'h02;
  localparam logic [FUNCT_W-1:0] FUNCT_MULT = 6'h18;
  localparam logic [FUNCT_W-1:0] FUNCT_MFHI = 6'h10;
  localparam logic [FUNCT_W-1:0] FUNCT_MFLO = 6'h12;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_XOR, ALU_LUI,
    ALU_SLL, ALU_SRL, ALU_MULT, ALU_MFHI, ALU_MFLO, ALU_NONE
  } alu_op_e;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} mul_state_e;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      rs_data;
    logic [XLEN-1:0]      rt_data;
    logic [XLEN-1:0]      imm;
    logic [XLEN-1:0]      pc_plus4;
    logic [REG_AW-1:0]    rt_addr;
    logic [REG_AW-1:0]    rd_addr;
    logic [CTRL_W-1:0]    ctrl;
    logic [LMODE_W-1:0]   load_mode;
    logic [ALUOP_W-1:0]   alu_op;
  } idex_t;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      alu_result;
    logic [XLEN-1:0]      write_data;
    logic [XLEN-1:0]      branch_target;
    logic [REG_AW-1:0]    write_register;
    logic                 zero;
    logic [EX_CTRL_W-1:0] ctrl;
    logic [LMODE_W-1:0]   load_mode;
  } exmem_t;

  function automatic alu_op_e decode_alu(input logic [ALUOP_W-1:0] alu_op,
                                         input logic [FUNCT_W-1:0] funct);
    alu_op_e sel;
    sel = ALU_NONE;
    case (alu_op)
      ALUOP_ADD: sel = ALU_ADD;
      ALUOP_SUB: sel = ALU_SUB;
      ALUOP_AND: sel = ALU_AND;
      ALUOP_OR:  sel = ALU_OR;
      ALUOP_SLT: sel = ALU_SLT;
      ALUOP_LUI: sel = ALU_LUI;
      ALUOP_XOR: sel = ALU_XOR;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD:  sel = ALU_ADD;
          FUNCT_SUB:  sel = ALU_SUB;
          FUNCT_AND:  sel = ALU_AND;
          FUNCT_OR:   sel = ALU_OR;
          FUNCT_SLT:  sel = ALU_SLT;
          FUNCT_SLL:  sel = ALU_SLL;
          FUNCT_SRL:  sel = ALU_SRL;
          FUNCT_MULT: sel = ALU_MULT;
          FUNCT_MFHI: sel = ALU_MFHI;
          FUNCT_MFLO: sel = ALU_MFLO;
          default:    sel = ALU_NONE;
        endcase
      end
      default: sel = ALU_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ex_multiplier.sv
// Signed 32x32->64 iterative shift-add multiplier: one multiplier bit per cycle
// on magnitudes, sign applied to the accumulated product.
module ex_multiplier
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  mul_state_e           state;
  mul_state_e           state_nxt;
  logic [MUL_CNT_W-1:0] count;
  logic [PROD_W-1:0]    mcand;
  logic [PROD_W-1:0]    acc;
  logic [XLEN-1:0]      mplier;
  logic                 negate;
  logic [XLEN-1:0]      abs_a;
  logic [XLEN-1:0]      abs_b;

  assign abs_a = op_a[XLEN-1] ? XLEN'(-op_a) : op_a;
  assign abs_b = op_b[XLEN-1] ? XLEN'(-op_b) : op_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_MUL;
      S_MUL:   if (count == MUL_CNT_W'(XLEN - 1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_MUL:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Shift-add datapath; reset mid-run discards the partial product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      negate <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            count  <= '0;
            mcand  <= PROD_W'(abs_a);
            mplier <= abs_b;
            acc    <= '0;
            negate <= op_a[XLEN-1] ^ op_b[XLEN-1];
          end
        end
        S_MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + MUL_CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign product = negate ? PROD_W'(-acc) : acc;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, ALU, branch target, HI/LO with an
// iterative multiplier that stalls upstream, and the EX/MEM register.
module ex_stage
  import mips_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 id_valid,
  input  logic [XLEN-1:0]      read_data1,
  input  logic [XLEN-1:0]      read_data2,
  input  logic [XLEN-1:0]      extended_bits,
  input  logic [XLEN-1:0]      new_pc_value,
  input  logic [REG_AW-1:0]    instr_bits_20_16,
  input  logic [REG_AW-1:0]    instr_bits_15_11,
  input  logic [CTRL_W-1:0]    id_ctrl,
  input  logic [LMODE_W-1:0]   load_mode,
  input  logic [ALUOP_W-1:0]   ALUOp,
  output logic [XLEN-1:0]      ex_alu_result,
  output logic [XLEN-1:0]      ex_write_data,
  output logic [REG_AW-1:0]    ex_write_register,
  output logic [XLEN-1:0]      ex_branch_target,
  output logic                 ex_zero,
  output logic [EX_CTRL_W-1:0] ex_ctrl,
  output logic [LMODE_W-1:0]   ex_load_mode,
  output logic                 ex_valid,
  output logic                 stall
);

  idex_t             idex;
  idex_t             idex_nxt;
  exmem_t            exmem;
  exmem_t            exmem_nxt;
  logic [XLEN-1:0]   hi;
  logic [XLEN-1:0]   lo;
  alu_op_e           alu_sel;
  logic [XLEN-1:0]   op_b;
  logic [XLEN-1:0]   result;
  logic              reg_write;
  logic              is_mult;
  logic              mul_start;
  logic              mul_busy;
  logic              mul_done;
  logic [PROD_W-1:0] mul_product;

  always_comb begin
    idex_nxt           = '0;
    idex_nxt.valid     = id_valid;
    idex_nxt.rs_data   = read_data1;
    idex_nxt.rt_data   = read_data2;
    idex_nxt.imm       = extended_bits;
    idex_nxt.pc_plus4  = new_pc_value;
    idex_nxt.rt_addr   = instr_bits_20_16;
    idex_nxt.rd_addr   = instr_bits_15_11;
    idex_nxt.ctrl      = id_ctrl;
    idex_nxt.load_mode = load_mode;
    idex_nxt.alu_op    = ALUOp;
  end

  assign alu_sel = decode_alu(idex.alu_op, idex.imm[FUNCT_W-1:0]);
  assign op_b    = idex.ctrl[CTRL_ALU_SRC] ? idex.imm : idex.rt_data;

  // A valid mult in ID/EX stalls from its first cycle until the multiplier reaches DONE.
  assign is_mult   = idex.valid && (alu_sel == ALU_MULT);
  assign mul_start = is_mult && !mul_busy && !mul_done;
  assign stall     = mul_busy || mul_start;

  ex_multiplier u_mul (
    .clk     (CLK),
    .rst     (RST),
    .start   (mul_start),
    .op_a    (idex.rs_data),
    .op_b    (idex.rt_data),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    result    = '0;
    reg_write = idex.ctrl[CTRL_REG_WRITE];
    case (alu_sel)
      ALU_ADD:  result = idex.rs_data + op_b;
      ALU_SUB:  result = idex.rs_data - op_b;
      ALU_AND:  result = idex.rs_data & op_b;
      ALU_OR:   result = idex.rs_data | op_b;
      ALU_XOR:  result = idex.rs_data ^ op_b;
      ALU_SLT:  result = XLEN'($signed(idex.rs_data) < $signed(op_b));
      ALU_LUI:  result = idex.imm << 16;
      ALU_SLL:  result = op_b << idex.imm[10:6];
      ALU_SRL:  result = op_b >> idex.imm[10:6];
      ALU_MFHI: result = hi;
      ALU_MFLO: result = lo;
      ALU_MULT: reg_write = 1'b0;
      default:  reg_write = 1'b0;
    endcase
  end

  // Bubbles (invalid instruction or stalled mult) enter EX/MEM fully cleared.
  always_comb begin
    exmem_nxt = '0;
    if (idex.valid && !stall) begin
      exmem_nxt.valid          = 1'b1;
      exmem_nxt.alu_result     = result;
      exmem_nxt.write_data     = idex.rt_data;
      exmem_nxt.branch_target  = idex.pc_plus4 + (idex.imm << 2);
      exmem_nxt.write_register = idex.ctrl[CTRL_REG_DST] ? idex.rd_addr : idex.rt_addr;
      exmem_nxt.zero           = (result == '0);
      exmem_nxt.ctrl           = {reg_write, idex.ctrl[3:0]};
      exmem_nxt.load_mode      = idex.load_mode;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idex  <= '0;
      exmem <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      if (!stall) idex <= idex_nxt;
      exmem <= exmem_nxt;
      if (mul_done) begin
        hi <= mul_product[PROD_W-1:XLEN];
        lo <= mul_product[XLEN-1:0];
      end
    end
  end

  assign ex_alu_result     = exmem.alu_result;
  assign ex_write_data     = exmem.write_data;
  assign ex_write_register = exmem.write_register;
  assign ex_branch_target  = exmem.branch_target;
  assign ex_zero           = exmem.zero;
  assign ex_ctrl           = exmem.ctrl;
  assign ex_load_mode      = exmem.load_mode;
  assign ex_valid          = exmem.valid;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: transaction-level model plus directed literal checks.
module tb_ex_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        id_valid;
  logic [31:0] read_data1, read_data2, extended_bits, new_pc_value;
  logic [4:0]  instr_bits_20_16, instr_bits_15_11;
  logic [6:0]  id_ctrl;
  logic [1:0]  load_mode;
  logic [2:0]  ALUOp;
  logic [31:0] ex_alu_result, ex_write_data, ex_branch_target;
  logic [4:0]  ex_write_register;
  logic        ex_zero, ex_valid, stall;
  logic [4:0]  ex_ctrl;
  logic [1:0]  ex_load_mode;

  ex_stage dut (
    .CLK(CLK), .RST(RST), .id_valid(id_valid),
    .read_data1(read_data1), .read_data2(read_data2),
    .extended_bits(extended_bits), .new_pc_value(new_pc_value),
    .instr_bits_20_16(instr_bits_20_16), .instr_bits_15_11(instr_bits_15_11),
    .id_ctrl(id_ctrl), .load_mode(load_mode), .ALUOp(ALUOp),
    .ex_alu_result(ex_alu_result), .ex_write_data(ex_write_data),
    .ex_write_register(ex_write_register), .ex_branch_target(ex_branch_target),
    .ex_zero(ex_zero), .ex_ctrl(ex_ctrl), .ex_load_mode(ex_load_mode),
    .ex_valid(ex_valid), .stall(stall)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic v; logic [31:0] rs, rt, imm, pc; logic [4:0] rta, rda;
    logic [6:0] ctrl; logic [1:0] lm; logic [2:0] op;
  } ins_t;

  typedef struct packed {
    logic v; logic [31:0] alu, wdata, bt; logic [4:0] wreg;
    logic zero; logic [4:0] ctrl; logic [1:0] lm;
  } out_t;

  int errors = 0;
  int checks = 0;

  // Model: instruction sitting in EX, remaining stall cycles, HI/LO, expected outputs.
  ins_t        m_idex;
  int          m_left;
  logic [31:0] m_hi, m_lo;
  out_t        m_out;
  logic        m_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ins_t mk(input logic v, input logic [31:0] rs, input logic [31:0] rt,
                              input logic [31:0] imm, input logic [31:0] pc,
                              input logic [4:0] rta, input logic [4:0] rda,
                              input logic [6:0] ctrl, input logic [1:0] lm, input logic [2:0] op);
    ins_t i;
    i.v = v; i.rs = rs; i.rt = rt; i.imm = imm; i.pc = pc;
    i.rta = rta; i.rda = rda; i.ctrl = ctrl; i.lm = lm; i.op = op;
    return i;
  endfunction

  function automatic logic is_mult(input ins_t i);
    return i.v && i.op == 3'd2 && i.imm[5:0] == 6'h18;
  endfunction

  // Architectural result of one instruction given current HI/LO.
  function automatic out_t exec(input ins_t i, input logic [31:0] hi, input logic [31:0] lo);
    out_t o;
    logic [31:0] b, r;
    logic rw;
    o = '0;
    if (!i.v) return o;
    b  = i.ctrl[4] ? i.imm : i.rt;
    r  = 32'd0;
    rw = i.ctrl[5];
    case (i.op)
      3'd0: r = i.rs + b;
      3'd1: r = i.rs - b;
      3'd2: begin
        case (i.imm[5:0])
          6'h20: r = i.rs + b;
          6'h22: r = i.rs - b;
          6'h24: r = i.rs & b;
          6'h25: r = i.rs | b;
          6'h2A: r = ($signed(i.rs) < $signed(b)) ? 32'd1 : 32'd0;
          6'h00: r = b << i.imm[10:6];
          6'h02: r = b >> i.imm[10:6];
          6'h18: rw = 1'b0;
          6'h10: r = hi;
          6'h12: r = lo;
          default: rw = 1'b0;
        endcase
      end
      3'd3: r = i.rs & b;
      3'd4: r = i.rs | b;
      3'd5: r = ($signed(i.rs) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: r = i.imm << 16;
      default: r = i.rs ^ b;
    endcase
    o.v = 1'b1; o.alu = r; o.wdata = i.rt; o.bt = i.pc + (i.imm << 2);
    o.wreg = i.ctrl[6] ? i.rda : i.rta; o.zero = (r == 32'd0);
    o.ctrl = {rw, i.ctrl[3:0]}; o.lm = i.lm;
    return o;
  endfunction

  task automatic model_reset();
    m_idex = '0; m_left = 0; m_hi = '0; m_lo = '0; m_out = '0; m_stall = 1'b0;
  endtask

  // A mult sits in EX for 33 stalled cycles, then retires and updates HI/LO.
  task automatic model_edge(input ins_t cur);
    logic signed [63:0] p;
    if (m_left > 0) begin
      m_out = '0;
      m_left--;
    end else begin
      m_out = exec(m_idex, m_hi, m_lo);
      if (is_mult(m_idex)) begin
        p = 64'($signed(m_idex.rs)) * 64'($signed(m_idex.rt));
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      m_idex = cur;
      m_left = is_mult(cur) ? 33 : 0;
    end
    m_stall = (m_left > 0);
  endtask

  task automatic drive(input ins_t i);
    id_valid = i.v; read_data1 = i.rs; read_data2 = i.rt; extended_bits = i.imm;
    new_pc_value = i.pc; instr_bits_20_16 = i.rta; instr_bits_15_11 = i.rda;
    id_ctrl = i.ctrl; load_mode = i.lm; ALUOp = i.op;
  endtask

  task automatic compare();
    chk("stall", 32'(stall), 32'(m_stall));
    chk("ex_valid", 32'(ex_valid), 32'(m_out.v));
    chk("ex_ctrl", 32'(ex_ctrl), 32'(m_out.ctrl));
    if (m_out.v) begin
      chk("ex_alu_result", ex_alu_result, m_out.alu);
      chk("ex_write_data", ex_write_data, m_out.wdata);
      chk("ex_branch_target", ex_branch_target, m_out.bt);
      chk("ex_write_register", 32'(ex_write_register), 32'(m_out.wreg));
      chk("ex_zero", 32'(ex_zero), 32'(m_out.zero));
      chk("ex_load_mode", 32'(ex_load_mode), 32'(m_out.lm));
    end
  endtask

  // Entered and left at posedge+1; inputs are captured at the posedge inside.
  task automatic step(input ins_t i);
    drive(i);
    @(negedge CLK);
    compare();
    @(posedge CLK);
    model_edge(i);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_alu"}, ex_alu_result, 32'd0);
    chk({tag, "_wdata"}, ex_write_data, 32'd0);
    chk({tag, "_wreg"}, 32'(ex_write_register), 32'd0);
    chk({tag, "_bt"}, ex_branch_target, 32'd0);
    chk({tag, "_zero"}, 32'(ex_zero), 32'd0);
    chk({tag, "_ctrl"}, 32'(ex_ctrl), 32'd0);
    chk({tag, "_lm"}, 32'(ex_load_mode), 32'd0);
    chk({tag, "_valid"}, 32'(ex_valid), 32'd0);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic ins_t rand_ins();
    ins_t i;
    logic [5:0] f;
    i = mk($urandom_range(0, 7) != 0, pick32(), pick32(), $urandom, $urandom,
           5'($urandom), 5'($urandom), 7'($urandom), 2'($urandom), 3'($urandom_range(0, 7)));
    if (i.op == 3'd2) begin
      case ($urandom_range(0, 10))
        0: f = 6'h20; 1: f = 6'h22; 2: f = 6'h24; 3: f = 6'h25;
        4: f = 6'h2A; 5: f = 6'h00; 6: f = 6'h02; 7: f = 6'h18;
        8: f = 6'h10; 9: f = 6'h12; default: f = 6'h3F;
      endcase
      i.imm[5:0] = f;
      i.ctrl[4]  = 1'b0;
    end
    return i;
  endfunction

  ins_t bub;
  int   n;

  initial begin
    bub = '0;
    drive(bub);
    model_reset();
    #1 RST = 1'b1;
    #2 chk_all_zero("reset");
    @(posedge CLK);
    #1 RST = 1'b0;

    // add via R-type funct 0x20 into rd=3
    step(mk(1'b1, 32'd5, 32'd7, 32'h20, 32'h0, 5'd9, 5'd3, 7'b1100000, 2'd0, 3'b010));
    step(bub);
    chk("lit_add_result", ex_alu_result, 32'd12);
    chk("lit_add_wreg", 32'(ex_write_register), 32'd3);
    chk("lit_add_valid", 32'(ex_valid), 32'd1);

    // beq-style compare and branch target
    step(mk(1'b1, 32'd9, 32'd9, 32'h4, 32'h100, 5'd0, 5'd0, 7'b0000001, 2'd0, 3'b001));
    step(bub);
    chk("lit_br_zero", 32'(ex_zero), 32'd1);
    chk("lit_br_target", ex_branch_target, 32'h110);

    // wrap-around add immediate, then signed slt
    step(mk(1'b1, 32'h7FFF_FFFF, 32'd0, 32'd1, 32'h0, 5'd1, 5'd0, 7'b0110000, 2'd0, 3'b000));
    step(mk(1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0, 5'd2, 5'd0, 7'b0100000, 2'd0, 3'b101));
    chk("lit_wrap", ex_alu_result, 32'h8000_0000);
    step(bub);
    chk("lit_slt", ex_alu_result, 32'd1);

    // bubble with every control bit set
    step(mk(1'b0, 32'd1, 32'd2, 32'd3, 32'd4, 5'd5, 5'd6, 7'h7F, 2'd3, 3'b000));
    step(bub);
    chk("lit_bubble_valid", 32'(ex_valid), 32'd0);
    chk("lit_bubble_ctrl", 32'(ex_ctrl), 32'd0);

    // mult -3*4, then mflo and mfhi
    step(mk(1'b1, 32'hFFFF_FFFD, 32'd4, 32'h18, 32'h0, 5'd0, 5'd0, 7'b1100000, 2'd0, 3'b010));
    n = 0;
    while (stall === 1'b1 && n < 50) begin
      n++;
      step(mk(1'b1, 32'd0, 32'd0, 32'h12, 32'h0, 5'd0, 5'd8, 7'b1100000, 2'd0, 3'b010));
    end
    chk("lit_mult_stall_cycles", 32'(n), 32'd33);
    step(mk(1'b1, 32'd0, 32'd0, 32'h12, 32'h0, 5'd0, 5'd8, 7'b1100000, 2'd0, 3'b010));
    step(mk(1'b1, 32'd0, 32'd0, 32'h10, 32'h0, 5'd0, 5'd9, 7'b1100000, 2'd0, 3'b010));
    chk("lit_mflo", ex_alu_result, 32'hFFFF_FFF4);
    step(bub);
    chk("lit_mfhi", ex_alu_result, 32'hFFFF_FFFF);

    // randomized traffic against the model
    for (int k = 0; k < 800; k++) step(rand_ins());

    // reset during MUL cycle 10 aborts the multiply
    step(mk(1'b1, 32'd6, 32'd7, 32'h18, 32'h0, 5'd0, 5'd0, 7'b1100000, 2'd0, 3'b010));
    step(bub);
    for (int k = 0; k < 10; k++) step(bub);
    #1 RST = 1'b1;
    #1 chk_all_zero("midmul_reset");
    model_reset();
    @(posedge CLK);
    #1 RST = 1'b0;
    step(mk(1'b1, 32'd0, 32'd0, 32'h10, 32'h0, 5'd0, 5'd4, 7'b1100000, 2'd0, 3'b010));
    step(mk(1'b1, 32'd0, 32'd0, 32'h12, 32'h0, 5'd0, 5'd5, 7'b1100000, 2'd0, 3'b010));
    chk("lit_hi_after_abort", ex_alu_result, 32'd0);
    step(bub);
    chk("lit_lo_after_abort", ex_alu_result, 32'd0);
    for (int k = 0; k < 40; k++) step(bub);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
